peri_serial_rx: RTL and testbench
=================================

// Module: peri_serial_rx
// PURPOSE
//  Receive end of the 3-wire peripheral link (P_CLOCK, P_DATA, P_CS) driven by the computer core.
//  Synchronises the three asynchronous lines into the local clock domain and shifts in MSB-first words.
//  Presents each complete frame on a valid/ready output port, with framing-error and overrun reporting.
//  Sits on the receiving board/FPGA (or in loopback on GPIO1_D) in front of a display/LED sink.
// PARAMETERS
//  WIDTH         16  bits per frame (matches 16-bit register width); legal 2..32
//  CS_ACTIVE_LOW 1   1: frame active while P_CS==0; 0: active while P_CS==1
//  SYNC_STAGES   2   flops in each input synchroniser; legal 2..3
// PORTS
//  clock         in   1      system clock; all logic on rising edge
//  reset         in   1      synchronous, active-high
//  P_CLOCK       in   1      serial clock from transmitter, async; data sampled on its rising edge
//  P_DATA        in   1      serial data, async, MSB first
//  P_CS          in   1      frame select, async, polarity per CS_ACTIVE_LOW
//  rx_data       out  WIDTH  last committed word; stable while rx_valid=1
//  rx_valid      out  1      word available; held until accepted
//  rx_ready      in   1      consumer accepts word when rx_valid&rx_ready
//  frame_err     out  1      one-cycle pulse: frame ended with bit count != WIDTH
//  overrun       out  1      sticky: a word completed while previous still unaccepted
//  clear_overrun in   1      clears overrun (clear wins over a same-cycle set)
//  busy          out  1      1 while FSM not IDLE
// BEHAVIOUR
//  Reset: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, bit count=0,
//   sync flops loaded to inactive levels (P_CLOCK=0, P_DATA=0, P_CS=inactive).
//  Input path: SYNC_STAGES flops per line, then one history flop on P_CLOCK; rise = sync&~hist.
//   Pin edge to internal event latency = SYNC_STAGES+1 cycles. P_CLOCK high/low each >= SYNC_STAGES+1 clock periods.
//  P_DATA sampled from its synchronised value in the same cycle rise is detected.
//  FSM: IDLE -> RECV when synchronised CS becomes active (count cleared, shift reg cleared).
//   RECV: on rise shift {sr[WIDTH-2:0],data}, count++; count reaching WIDTH -> FULL.
//   FULL: further rise -> ERR (extra bits). CS inactive -> commit, -> IDLE.
//   RECV with CS inactive -> frame_err pulse, discard, -> IDLE (includes zero-bit frames).
//   ERR: wait for CS inactive, then frame_err pulse, discard, -> IDLE.
//  rise and CS-inactive in same cycle: CS-inactive wins; the edge is ignored.
//  Commit (cycle after CS inactive detected in FULL):
//   rx_valid=0 or accept this cycle -> rx_data<=sr, rx_valid<=1 (accept+commit keeps valid=1, new data).
//   rx_valid=1 and no accept -> word dropped, rx_data unchanged, overrun<=1.
//  Accept without commit -> rx_valid<=0 next cycle. rx_data never changes except on commit.
//  Count width = $clog2(WIDTH+1); never wraps (saturates behaviour via FULL/ERR).
//  Reset mid-frame: FSM to IDLE, partial word discarded; a frame already in progress on the pins
//   is not joined -- receiver waits for CS inactive then active again (IDLE requires CS edge,
//   tracked by a cs_hist flop reset to inactive, so CS held active through reset is ignored).
// STRUCTURE
//  Package peri_pkg: rx_state_t enum {IDLE, RECV, FULL, ERR}; PERI_WORD_W=16 constant.
//  Sub-module peri_sync (param STAGES, INIT): one N-flop synchroniser, instanced x3.
//  Top holds edge detect, FSM, shift/count datapath, output register and flags.
// TESTING
//  1 Frame 16'hA5C3, slow P_CLOCK (8 clk/half-period), rx_ready=1 -> rx_valid 1 cycle, rx_data=A5C3, no flags.
//  2 CS drops after 9 bits -> frame_err one pulse, rx_valid stays 0, rx_data unchanged.
//  3 17 rising edges in one frame -> frame_err pulse at CS end, no commit.
//  4 rx_ready=0, send 1234 then 5678 -> rx_data=1234 held, overrun=1; clear_overrun -> 0; accept -> valid 0.
//  5 rx_valid=1 with word 1111, rx_ready asserted in commit cycle of 2222 -> valid stays 1, rx_data=2222, no overrun.
//  6 reset asserted after 5 bits, released with CS still active -> no word, no frame_err until new frame; next frame BEEF received correctly.

Source files
------------

// File: rtl/peri_pkg.sv
// ============================================================================
// Module : peri_pkg
// Brief  : Shared types and constants for the peripheral serial link receiver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package peri_pkg;

  localparam int PERI_WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    FULL = 2'd2,
    ERR  = 2'd3
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/peri_sync.sv
// ============================================================================
// Module : peri_sync
// Brief  : N-flop synchroniser for one asynchronous input line.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module peri_sync #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync <= {STAGES{INIT}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/peri_serial_rx.sv
// ============================================================================
// Module : peri_serial_rx
// Brief  : 3-wire serial link receiver with valid/ready output, framing error
//          and overrun reporting.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module peri_serial_rx
  import peri_pkg::*;
#(
  parameter int WIDTH         = PERI_WORD_W,
  parameter int CS_ACTIVE_LOW = 1,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             P_CLOCK,
  input  logic             P_DATA,
  input  logic             P_CS,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             overrun,
  input  logic             clear_overrun,
  output logic             busy
);

  localparam int             CW         = $clog2(WIDTH + 1);
  localparam logic           c_cs_idle  = (CS_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [CW-1:0]  c_last_bit = CW'(WIDTH - 1);

  logic w_clk_s;
  logic w_data_s;
  logic w_cs_s;

  peri_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_clk (
    .clock (clock),
    .reset (reset),
    .d     (P_CLOCK),
    .q     (w_clk_s)
  );

  peri_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_data (
    .clock (clock),
    .reset (reset),
    .d     (P_DATA),
    .q     (w_data_s)
  );

  peri_sync #(.STAGES(SYNC_STAGES), .INIT(c_cs_idle)) u_sync_cs (
    .clock (clock),
    .reset (reset),
    .d     (P_CS),
    .q     (w_cs_s)
  );

  rx_state_t              r_state;
  logic [WIDTH-1:0]       r_shift;
  logic [CW-1:0]          r_count;
  logic [WIDTH-1:0]       r_data;
  logic                   r_valid;
  logic                   r_frame_err;
  logic                   r_overrun;
  logic                   r_busy;
  logic                   r_clk_hist;
  logic                   r_cs_hist;
  logic [SYNC_STAGES-1:0] r_warm;

  logic w_cs_act;
  logic w_rise;
  logic w_warm;
  logic w_cs_start;
  logic w_accept;
  logic w_commit;

  assign w_cs_act   = w_cs_s ^ c_cs_idle;
  assign w_rise     = w_clk_s & ~r_clk_hist;
  assign w_warm     = r_warm[SYNC_STAGES-1];
  assign w_cs_start = w_warm & w_cs_act & ~r_cs_hist;
  assign w_accept   = r_valid & rx_ready;
  assign w_commit   = (r_state == FULL) & ~w_cs_act;

  // Until the synchronisers have flushed after reset, the CS history is held
  // "active" so a frame already running on the pins is never joined mid-way.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_warm <= '0;
    end else begin
      r_warm <= {r_warm[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_count     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
      r_clk_hist  <= 1'b0;
      r_cs_hist   <= 1'b0;
    end else begin
      r_clk_hist  <= w_clk_s;
      r_cs_hist   <= w_warm ? w_cs_act : 1'b1;
      r_frame_err <= 1'b0;

      // CS going inactive is tested first so it wins over a same-cycle rise.
      case (r_state)
        IDLE: begin
          if (w_cs_start) begin
            r_state <= RECV;
            r_shift <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
          end
        end
        RECV: begin
          if (!w_cs_act) begin
            r_frame_err <= 1'b1;
            r_state     <= IDLE;
            r_busy      <= 1'b0;
          end else if (w_rise) begin
            r_shift <= {r_shift[WIDTH-2:0], w_data_s};
            r_count <= r_count + 1'b1;
            if (r_count == c_last_bit) begin
              r_state <= FULL;
            end
          end
        end
        FULL: begin
          if (!w_cs_act) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_rise) begin
            r_state <= ERR;
          end
        end
        ERR: begin
          if (!w_cs_act) begin
            r_frame_err <= 1'b1;
            r_state     <= IDLE;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // A same-cycle accept frees the slot, so the new word replaces the old.
      if (w_commit) begin
        if (!r_valid || w_accept) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end

      if (clear_overrun) begin
        r_overrun <= 1'b0;
      end else if (w_commit && r_valid && !w_accept) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_peri_serial_rx.sv
// ============================================================================
// Module : tb_peri_serial_rx
// Brief  : Directed self-checking bench for peri_serial_rx (16-bit, CS low).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_peri_serial_rx;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        P_CLOCK = 1'b0;
  logic        P_DATA = 1'b0;
  logic        P_CS = 1'b1;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        frame_err;
  logic        overrun;
  logic        clear_overrun = 1'b0;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid_tot = 0;
  int n_ferr_tot = 0;
  int v0 = 0;
  int f0 = 0;
  logic [15:0] last_data = 16'h0;

  peri_serial_rx #(
    .WIDTH         (16),
    .CS_ACTIVE_LOW (1),
    .SYNC_STAGES   (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .P_CLOCK       (P_CLOCK),
    .P_DATA        (P_DATA),
    .P_CS          (P_CS),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .frame_err     (frame_err),
    .overrun       (overrun),
    .clear_overrun (clear_overrun),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset) begin
      if (rx_valid) begin
        n_valid_tot++;
        last_data = rx_data;
      end
      if (frame_err) n_ferr_tot++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic snap();
    v0 = n_valid_tot;
    f0 = n_ferr_tot;
  endtask

  // Lowers CS and clocks out bits[n-1:0] MSB first, leaving CS active.
  task automatic send_body(input logic [31:0] bits, input int n);
    P_CS = 1'b0;
    repeat (8) tick();
    for (int i = n - 1; i >= 0; i--) begin
      P_DATA = bits[i];
      repeat (8) tick();
      P_CLOCK = 1'b1;
      repeat (8) tick();
      P_CLOCK = 1'b0;
    end
  endtask

  task automatic end_frame();
    repeat (8) tick();
    P_CS = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (4) tick();
    reset = 1'b0;
    repeat (4) tick();

    check_eq("reset_data", 32'(rx_data), 32'h0);
    check_eq("reset_valid", 32'(rx_valid), 32'h0);
    check_eq("reset_ferr", 32'(frame_err), 32'h0);
    check_eq("reset_overrun", 32'(overrun), 32'h0);
    check_eq("reset_busy", 32'(busy), 32'h0);

    // 1: clean frame with consumer ready
    rx_ready = 1'b1;
    snap();
    send_body(32'hA5C3, 16);
    check_eq("t1_busy_mid", 32'(busy), 32'h1);
    end_frame();
    check_eq("t1_valid_cycles", 32'(n_valid_tot - v0), 32'd1);
    check_eq("t1_last_data", 32'(last_data), 32'hA5C3);
    check_eq("t1_rx_data", 32'(rx_data), 32'hA5C3);
    check_eq("t1_ferr", 32'(n_ferr_tot - f0), 32'd0);
    check_eq("t1_overrun", 32'(overrun), 32'h0);
    check_eq("t1_busy_end", 32'(busy), 32'h0);

    // 2: short frame (9 bits)
    snap();
    send_body(32'h1FF, 9);
    end_frame();
    check_eq("t2_ferr", 32'(n_ferr_tot - f0), 32'd1);
    check_eq("t2_valid", 32'(n_valid_tot - v0), 32'd0);
    check_eq("t2_rx_data", 32'(rx_data), 32'hA5C3);

    // 3: 17 rising edges
    snap();
    send_body(32'h1_2345, 17);
    check_eq("t3_ferr_before_cs", 32'(n_ferr_tot - f0), 32'd0);
    end_frame();
    check_eq("t3_ferr", 32'(n_ferr_tot - f0), 32'd1);
    check_eq("t3_valid", 32'(n_valid_tot - v0), 32'd0);
    check_eq("t3_rx_data", 32'(rx_data), 32'hA5C3);

    // 4: overrun with consumer stalled
    rx_ready = 1'b0;
    send_body(32'h1234, 16);
    end_frame();
    check_eq("t4_valid_1", 32'(rx_valid), 32'h1);
    check_eq("t4_data_1", 32'(rx_data), 32'h1234);
    check_eq("t4_overrun_0", 32'(overrun), 32'h0);
    send_body(32'h5678, 16);
    end_frame();
    check_eq("t4_data_held", 32'(rx_data), 32'h1234);
    check_eq("t4_overrun_set", 32'(overrun), 32'h1);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    check_eq("t4_overrun_clr", 32'(overrun), 32'h0);
    check_eq("t4_valid_still", 32'(rx_valid), 32'h1);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check_eq("t4_valid_accepted", 32'(rx_valid), 32'h0);
    check_eq("t4_data_after_acc", 32'(rx_data), 32'h1234);

    // 5: accept coinciding with commit
    send_body(32'h1111, 16);
    end_frame();
    check_eq("t5_data_1111", 32'(rx_data), 32'h1111);
    check_eq("t5_valid_1111", 32'(rx_valid), 32'h1);
    send_body(32'h2222, 16);
    repeat (8) tick();
    P_CS = 1'b1;
    tick();
    tick();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check_eq("t5_valid_kept", 32'(rx_valid), 32'h1);
    check_eq("t5_data_2222", 32'(rx_data), 32'h2222);
    check_eq("t5_overrun", 32'(overrun), 32'h0);
    repeat (8) tick();
    rx_ready = 1'b1;
    tick();
    check_eq("t5_valid_drained", 32'(rx_valid), 32'h0);

    // 6: reset mid-frame with CS held active through reset
    send_body(32'h15, 5);
    reset = 1'b1;
    repeat (3) tick();
    check_eq("t6_data_reset", 32'(rx_data), 32'h0);
    reset = 1'b0;
    snap();
    for (int i = 0; i < 3; i++) begin
      P_DATA = 1'b1;
      repeat (8) tick();
      P_CLOCK = 1'b1;
      check_eq("t6_busy_ignored", 32'(busy), 32'h0);
      repeat (8) tick();
      P_CLOCK = 1'b0;
    end
    end_frame();
    check_eq("t6_no_ferr", 32'(n_ferr_tot - f0), 32'd0);
    check_eq("t6_no_valid", 32'(n_valid_tot - v0), 32'd0);
    snap();
    send_body(32'hBEEF, 16);
    end_frame();
    check_eq("t6_valid", 32'(n_valid_tot - v0), 32'd1);
    check_eq("t6_data", 32'(last_data), 32'hBEEF);
    check_eq("t6_ferr", 32'(n_ferr_tot - f0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
